// File: rtl/debug_node_mailbox_if.sv
// Bundle of per-node handshake inputs and mailbox outputs shared by the
// demo user logic (master) and the debug_node_mailbox block (slave).
interface debug_node_mailbox_if #(
  parameter int NODES = 4,
  parameter int BITS  = 128
);
  logic [NODES-1:0]      in_tgl;
  logic [NODES*BITS-1:0] in_data;
  logic                  hold;
  logic [NODES-1:0]      clr_overrun;
  logic [NODES*BITS-1:0] out_data;
  logic [NODES*BITS-1:0] identity;
  logic [NODES-1:0]      update;
  logic [NODES-1:0]      overrun;
  logic [NODES*8-1:0]    update_count;
  logic [NODES-1:0]      led;

  modport master (
    output in_tgl, in_data, hold, clr_overrun,
    input  out_data, identity, update, overrun, update_count, led
  );

  modport slave (
    input  in_tgl, in_data, hold, clr_overrun,
    output out_data, identity, update, overrun, update_count, led
  );
endinterface

// File: rtl/debug_node_mailbox.sv
// Per-node mailbox: toggle/data handshake drives opcode updates (load/set/
// clear/flip) of a registered outgoing word, with a global hold and one-deep pending slot.
module debug_node_mailbox #(
  parameter int          NODES   = 4,
  parameter int          BITS    = 128,
  parameter int          LED_BIT = 0,
  parameter logic [31:0] ID_BASE = 32'h1122_3300
) (
  input  logic                 clk,
  input  logic                 rst_n,
  debug_node_mailbox_if.slave  bus
);

  logic [NODES-1:0]           tgl_prev_r;
  logic [NODES-1:0]           pend_valid_r;
  logic [NODES-1:0][BITS-1:0] pend_data_r;
  logic [NODES-1:0][BITS-1:0] out_r;
  logic [NODES-1:0][BITS-1:0] id_r;
  logic [NODES-1:0]           update_r;
  logic [NODES-1:0]           overrun_r;
  logic [NODES-1:0][7:0]      count_r;
  logic [NODES-1:0]           led_r;

  logic [NODES-1:0]           event_s;
  logic [NODES-1:0]           apply_s;
  logic [NODES-1:0]           pend_load_s;
  logic [NODES-1:0]           pend_valid_nxt_s;
  logic [NODES-1:0]           overrun_nxt_s;
  logic [NODES-1:0]           led_nxt_s;
  logic [NODES-1:0][BITS-1:0] word_s;
  logic [NODES-1:0][BITS-1:0] apply_word_s;
  logic [NODES-1:0][BITS-1:0] out_nxt_s;
  logic [NODES-1:0][BITS-1:0] id_s;
  logic [NODES-1:0][7:0]      count_nxt_s;

  function automatic logic [BITS-1:0] id_word(input int n);
    logic [BITS+31:0] ext;
    ext = {{BITS{1'b0}}, ID_BASE + 32'(n)};
    return ext[BITS-1:0];
  endfunction

  // Opcode lives in the top two bits; they are stripped from the payload so
  // the outgoing word's top two bits can never become set.
  function automatic logic [BITS-1:0] apply_op(input logic [BITS-1:0] cur,
                                               input logic [BITS-1:0] word);
    logic [BITS-1:0] p;
    p = word;
    p[BITS-1:BITS-2] = 2'b00;
    case (word[BITS-1:BITS-2])
      2'b00:   apply_op = p;
      2'b01:   apply_op = cur | p;
      2'b10:   apply_op = cur & ~p;
      2'b11:   apply_op = cur ^ p;
      default: apply_op = p;
    endcase
  endfunction

  // Per-channel event detection, pending-slot control and next output values.
  always_comb begin
    event_s          = {NODES{1'b0}};
    apply_s          = {NODES{1'b0}};
    pend_load_s      = {NODES{1'b0}};
    pend_valid_nxt_s = {NODES{1'b0}};
    overrun_nxt_s    = {NODES{1'b0}};
    led_nxt_s        = {NODES{1'b0}};
    word_s           = '0;
    apply_word_s     = '0;
    out_nxt_s        = '0;
    id_s             = '0;
    count_nxt_s      = '0;
    for (int n = 0; n < NODES; n++) begin
      word_s[n]      = bus.in_data[n*BITS +: BITS];
      event_s[n]     = bus.in_tgl[n] ^ tgl_prev_r[n];
      id_s[n]        = id_word(n);
      // A pending word always drains before a new one, so order is preserved.
      pend_load_s[n] = event_s[n] & (bus.hold | pend_valid_r[n]);
      if (bus.hold) begin
        apply_s[n]          = 1'b0;
        apply_word_s[n]     = word_s[n];
        pend_valid_nxt_s[n] = pend_valid_r[n] | event_s[n];
      end else if (pend_valid_r[n]) begin
        apply_s[n]          = 1'b1;
        apply_word_s[n]     = pend_data_r[n];
        pend_valid_nxt_s[n] = event_s[n];
      end else begin
        apply_s[n]          = event_s[n];
        apply_word_s[n]     = word_s[n];
        pend_valid_nxt_s[n] = 1'b0;
      end
      if (bus.hold && event_s[n] && pend_valid_r[n]) begin
        overrun_nxt_s[n] = 1'b1;
      end else if (bus.clr_overrun[n]) begin
        overrun_nxt_s[n] = 1'b0;
      end else begin
        overrun_nxt_s[n] = overrun_r[n];
      end
      if (apply_s[n]) begin
        out_nxt_s[n] = apply_op(out_r[n], apply_word_s[n]);
      end else begin
        out_nxt_s[n] = out_r[n];
      end
      if (apply_s[n] && (count_r[n] != 8'd255)) begin
        count_nxt_s[n] = count_r[n] + 8'd1;
      end else begin
        count_nxt_s[n] = count_r[n];
      end
      led_nxt_s[n] = ~out_nxt_s[n][LED_BIT];
    end
  end

  // State and output registers; reset captures in_tgl so no spurious event follows.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tgl_prev_r   <= bus.in_tgl;
      pend_valid_r <= {NODES{1'b0}};
      pend_data_r  <= '0;
      out_r        <= '0;
      update_r     <= {NODES{1'b0}};
      overrun_r    <= {NODES{1'b0}};
      count_r      <= '0;
      led_r        <= {NODES{1'b1}};
      id_r         <= id_s;
    end else begin
      tgl_prev_r   <= bus.in_tgl;
      pend_valid_r <= pend_valid_nxt_s;
      for (int n = 0; n < NODES; n++) begin
        if (pend_load_s[n]) begin
          pend_data_r[n] <= word_s[n];
        end else begin
          pend_data_r[n] <= pend_data_r[n];
        end
      end
      out_r        <= out_nxt_s;
      update_r     <= apply_s;
      overrun_r    <= overrun_nxt_s;
      count_r      <= count_nxt_s;
      led_r        <= led_nxt_s;
      id_r         <= id_s;
    end
  end

  assign bus.out_data     = out_r;
  assign bus.identity     = id_r;
  assign bus.update       = update_r;
  assign bus.overrun      = overrun_r;
  assign bus.update_count = count_r;
  assign bus.led          = led_r;

endmodule

// File: tb/tb_debug_node_mailbox.sv
// Randomized and directed checks of debug_node_mailbox against a queue-based
// behavioural model of the mailbox rules.
module tb_debug_node_mailbox;

  localparam int          NODES   = 4;
  localparam int          BITS    = 128;
  localparam int          LED_BIT = 0;
  localparam logic [31:0] ID_BASE = 32'h1122_3300;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  debug_node_mailbox_if #(.NODES(NODES), .BITS(BITS)) ifc ();

  debug_node_mailbox #(.NODES(NODES), .BITS(BITS), .LED_BIT(LED_BIT), .ID_BASE(ID_BASE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  // Model state: the pending slot is a queue holding at most one word.
  logic [BITS-1:0] m_out  [NODES];
  int              m_cnt  [NODES];
  bit              m_ovr  [NODES];
  bit              m_upd  [NODES];
  bit              m_prev [NODES];
  logic [BITS-1:0] m_pend [NODES][$];

  function automatic logic [BITS-1:0] mkw(input int op, input logic [BITS-1:0] p);
    logic [1:0] o;
    o = op[1:0];
    return {o, p[BITS-3:0]};
  endfunction

  function automatic logic [BITS-1:0] rand_word();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    return BITS'(r);
  endfunction

  function automatic logic [BITS-1:0] m_apply(input logic [BITS-1:0] cur, input logic [BITS-1:0] w);
    logic [BITS-1:0] p;
    int op;
    p  = w % (BITS'(1) << (BITS-2));
    op = int'(w >> (BITS-2));
    if (op == 0) return p;
    if (op == 1) return cur | p;
    if (op == 2) return cur & ~p;
    return cur ^ p;
  endfunction

  function automatic logic [NODES*BITS-1:0] exp_out();
    logic [NODES*BITS-1:0] v;
    for (int i = 0; i < NODES; i++) v[i*BITS +: BITS] = m_out[i];
    return v;
  endfunction

  function automatic logic [NODES-1:0] exp_upd();
    logic [NODES-1:0] v;
    for (int i = 0; i < NODES; i++) v[i] = m_upd[i];
    return v;
  endfunction

  function automatic logic [NODES-1:0] exp_ovr();
    logic [NODES-1:0] v;
    for (int i = 0; i < NODES; i++) v[i] = m_ovr[i];
    return v;
  endfunction

  function automatic logic [NODES-1:0] exp_led();
    logic [NODES-1:0] v;
    for (int i = 0; i < NODES; i++) v[i] = ~m_out[i][LED_BIT];
    return v;
  endfunction

  function automatic logic [NODES*8-1:0] exp_cnt();
    logic [NODES*8-1:0] v;
    for (int i = 0; i < NODES; i++) v[i*8 +: 8] = 8'(m_cnt[i]);
    return v;
  endfunction

  task automatic model_step();
    bit              ev;
    bit              ap;
    logic [BITS-1:0] w;
    logic [BITS-1:0] aw;
    for (int i = 0; i < NODES; i++) begin
      m_upd[i] = 1'b0;
      if (!rst_n) begin
        m_out[i] = '0;
        m_cnt[i] = 0;
        m_ovr[i] = 1'b0;
        m_pend[i].delete();
        m_prev[i] = ifc.in_tgl[i];
      end else begin
        ev = (ifc.in_tgl[i] != m_prev[i]);
        m_prev[i] = ifc.in_tgl[i];
        w  = ifc.in_data[i*BITS +: BITS];
        ap = 1'b0;
        aw = '0;
        if (ifc.clr_overrun[i]) m_ovr[i] = 1'b0;
        if (!ifc.hold && m_pend[i].size() > 0) begin
          ap = 1'b1;
          aw = m_pend[i].pop_front();
        end else if (!ifc.hold && ev) begin
          ap = 1'b1;
          aw = w;
          ev = 1'b0;
        end
        if (ev) begin
          if (m_pend[i].size() > 0) begin
            m_ovr[i] = 1'b1;
            m_pend[i].delete();
          end
          m_pend[i].push_back(w);
        end
        if (ap) begin
          m_out[i] = m_apply(m_out[i], aw);
          m_upd[i] = 1'b1;
          if (m_cnt[i] < 255) m_cnt[i]++;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic send(input int ch, input logic [BITS-1:0] w);
    ifc.in_data[ch*BITS +: BITS] = w;
    ifc.in_tgl[ch] = ~ifc.in_tgl[ch];
  endtask

  task automatic test_reset();
    logic [NODES*BITS-1:0] id_exp;
    logic [BITS-1:0]       t;
    rst_n = 1'b0;
    ifc.hold = 1'b0;
    ifc.clr_overrun = '0;
    ifc.in_tgl = 4'b1010;
    for (int i = 0; i < NODES; i++) ifc.in_data[i*BITS +: BITS] = rand_word();
    tick();
    tick();
    for (int i = 0; i < NODES; i++) begin
      t = '0;
      t[31:0] = ID_BASE + 32'(i);
      id_exp[i*BITS +: BITS] = t;
    end
    nvec++; if (ifc.out_data !== '0) begin nerr++; $display("FAIL reset_out: got %h expected 0", ifc.out_data); end
    nvec++; if (ifc.led !== 4'b1111) begin nerr++; $display("FAIL reset_led: got %b expected 1111", ifc.led); end
    nvec++; if (ifc.identity[2*BITS +: BITS] !== 128'h1122_3302) begin nerr++; $display("FAIL reset_id2: got %h expected 11223302", ifc.identity[2*BITS +: BITS]); end
    nvec++; if (ifc.identity !== id_exp) begin nerr++; $display("FAIL reset_id: got %h expected %h", ifc.identity, id_exp); end
    nvec++; if (ifc.update !== 4'b0000) begin nerr++; $display("FAIL reset_upd: got %b expected 0000", ifc.update); end
    nvec++; if (ifc.update_count !== '0 || ifc.overrun !== 4'b0000) begin nerr++; $display("FAIL reset_cnt_ovr: got %h/%b expected 0/0", ifc.update_count, ifc.overrun); end
    rst_n = 1'b1;
    tick();
    nvec++; if (ifc.update !== 4'b0000) begin nerr++; $display("FAIL post_reset_upd: got %b expected 0000", ifc.update); end
    tick();
    nvec++; if (ifc.out_data !== '0 || ifc.update !== 4'b0000) begin nerr++; $display("FAIL post_reset_quiet: got %h/%b expected 0/0", ifc.out_data, ifc.update); end
  endtask

  task automatic test_load();
    send(0, mkw(0, 128'h5));
    ifc.in_data[3*BITS +: BITS] = rand_word();
    tick();
    nvec++; if (ifc.out_data[0 +: BITS] !== 128'h5) begin nerr++; $display("FAIL load_out0: got %h expected 5", ifc.out_data[0 +: BITS]); end
    nvec++; if (ifc.update !== 4'b0001) begin nerr++; $display("FAIL load_upd: got %b expected 0001", ifc.update); end
    nvec++; if (ifc.update_count[7:0] !== 8'd1) begin nerr++; $display("FAIL load_cnt0: got %0d expected 1", ifc.update_count[7:0]); end
    nvec++; if (ifc.led !== 4'b1110) begin nerr++; $display("FAIL load_led: got %b expected 1110", ifc.led); end
    nvec++; if (ifc.out_data !== exp_out()) begin nerr++; $display("FAIL load_all: got %h expected %h", ifc.out_data, exp_out()); end
    tick();
    nvec++; if (ifc.update !== 4'b0000) begin nerr++; $display("FAIL load_pulse: got %b expected 0000", ifc.update); end
  endtask

  task automatic test_ops();
    logic [BITS-1:0] pay [4];
    logic [BITS-1:0] res [4];
    pay = '{128'hF0, 128'h0F, 128'h3C, 128'h81};
    res = '{128'hF0, 128'hFF, 128'hC3, 128'h42};
    for (int k = 0; k < 4; k++) begin
      send(1, mkw(k, pay[k] | (rand_word() & (128'h3 << (BITS-2)))));
      tick();
      nvec++; if (ifc.out_data[BITS +: BITS] !== res[k]) begin nerr++; $display("FAIL ops_out1_%0d: got %h expected %h", k, ifc.out_data[BITS +: BITS], res[k]); end
    end
    nvec++; if (ifc.update_count[15:8] !== 8'd4) begin nerr++; $display("FAIL ops_cnt1: got %0d expected 4", ifc.update_count[15:8]); end
    nvec++; if (ifc.out_data[2*BITS-1 -: 2] !== 2'b00) begin nerr++; $display("FAIL ops_opbits: got %b expected 00", ifc.out_data[2*BITS-1 -: 2]); end
    tick();
  endtask

  task automatic test_hold();
    ifc.hold = 1'b1;
    send(2, mkw(0, 128'h11));
    tick();
    send(2, mkw(0, 128'h22));
    tick();
    nvec++; if (ifc.out_data[2*BITS +: BITS] !== 128'h0 || ifc.update !== 4'b0000) begin nerr++; $display("FAIL hold_out2: got %h/%b expected 0/0000", ifc.out_data[2*BITS +: BITS], ifc.update); end
    nvec++; if (ifc.overrun !== 4'b0100) begin nerr++; $display("FAIL hold_ovr: got %b expected 0100", ifc.overrun); end
    ifc.hold = 1'b0;
    tick();
    nvec++; if (ifc.out_data[2*BITS +: BITS] !== 128'h22) begin nerr++; $display("FAIL release_out2: got %h expected 22", ifc.out_data[2*BITS +: BITS]); end
    nvec++; if (ifc.update_count[23:16] !== 8'd1 || ifc.update !== 4'b0100) begin nerr++; $display("FAIL release_cnt2: got %0d/%b expected 1/0100", ifc.update_count[23:16], ifc.update); end
    ifc.clr_overrun = 4'b0100;
    tick();
    ifc.clr_overrun = 4'b0000;
    nvec++; if (ifc.overrun !== 4'b0000) begin nerr++; $display("FAIL clr_ovr: got %b expected 0000", ifc.overrun); end
  endtask

  task automatic test_hold_event();
    ifc.hold = 1'b1;
    send(3, mkw(0, 128'hA));
    tick();
    ifc.hold = 1'b0;
    send(3, mkw(1, 128'h5));
    tick();
    nvec++; if (ifc.out_data[3*BITS +: BITS] !== 128'hA) begin nerr++; $display("FAIL order_first: got %h expected a", ifc.out_data[3*BITS +: BITS]); end
    tick();
    nvec++; if (ifc.out_data[3*BITS +: BITS] !== 128'hF) begin nerr++; $display("FAIL order_second: got %h expected f", ifc.out_data[3*BITS +: BITS]); end
    ifc.hold = 1'b1;
    send(3, mkw(0, 128'h1));
    tick();
    send(3, mkw(0, 128'h2));
    ifc.clr_overrun = 4'b1000;
    tick();
    ifc.clr_overrun = 4'b0000;
    nvec++; if (ifc.overrun[3] !== 1'b1) begin nerr++; $display("FAIL ovr_priority: got %b expected 1", ifc.overrun[3]); end
    ifc.hold = 1'b0;
    tick();
    nvec++; if (ifc.out_data !== exp_out()) begin nerr++; $display("FAIL ovr_drain: got %h expected %h", ifc.out_data, exp_out()); end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 300; k++) begin
      send(0, rand_word());
      tick();
      nvec++; if (ifc.out_data[0 +: BITS] !== m_out[0] || ifc.update[0] !== 1'b1) begin nerr++; $display("FAIL sat_step%0d: got %h/%b expected %h/1", k, ifc.out_data[0 +: BITS], ifc.update[0], m_out[0]); end
    end
    nvec++; if (ifc.update_count[7:0] !== 8'd255) begin nerr++; $display("FAIL sat_cnt0: got %0d expected 255", ifc.update_count[7:0]); end
  endtask

  task automatic test_reset_mid_hold();
    ifc.hold = 1'b1;
    send(1, mkw(0, 128'h77));
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ifc.hold = 1'b0;
    tick();
    nvec++; if (ifc.out_data !== '0 || ifc.update !== 4'b0000) begin nerr++; $display("FAIL rst_hold_a: got %h/%b expected 0/0000", ifc.out_data, ifc.update); end
    tick();
    nvec++; if (ifc.out_data !== '0 || ifc.update !== 4'b0000 || ifc.update_count !== '0) begin nerr++; $display("FAIL rst_hold_b: got %h/%b/%h expected 0", ifc.out_data, ifc.update, ifc.update_count); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst_n = ($urandom_range(99) != 0);
      ifc.hold = ($urandom_range(9) < 3);
      ifc.clr_overrun = NODES'($urandom());
      for (int i = 0; i < NODES; i++) begin
        if ($urandom_range(2) != 0) send(i, rand_word());
        else ifc.in_data[i*BITS +: BITS] = rand_word();
      end
      tick();
      nvec++; if (ifc.out_data !== exp_out()) begin nerr++; $display("FAIL rnd_out c%0d: got %h expected %h", c, ifc.out_data, exp_out()); end
      nvec++; if (ifc.update !== exp_upd()) begin nerr++; $display("FAIL rnd_upd c%0d: got %b expected %b", c, ifc.update, exp_upd()); end
      nvec++; if (ifc.overrun !== exp_ovr()) begin nerr++; $display("FAIL rnd_ovr c%0d: got %b expected %b", c, ifc.overrun, exp_ovr()); end
      nvec++; if (ifc.update_count !== exp_cnt()) begin nerr++; $display("FAIL rnd_cnt c%0d: got %h expected %h", c, ifc.update_count, exp_cnt()); end
      nvec++; if (ifc.led !== exp_led()) begin nerr++; $display("FAIL rnd_led c%0d: got %b expected %b", c, ifc.led, exp_led()); end
    end
    rst_n = 1'b1;
    ifc.hold = 1'b0;
    ifc.clr_overrun = '0;
    tick();
  endtask

  initial begin
    ifc.in_tgl = '0;
    ifc.in_data = '0;
    ifc.hold = 1'b0;
    ifc.clr_overrun = '0;
    @(negedge clk);
    test_reset();
    test_load();
    test_ops();
    test_hold();
    test_hold_event();
    test_saturation();
    test_reset_mid_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
